// File: rtl/parsepacket_if.sv
// Bus between the lasernet receive deserializer side and the packet parser.
// The master drives packets and sequence control; the slave (parser) returns fields and the BRAM write.
interface parsepacket_if;
    logic         control;
    logic [31:0]  IRS;
    logic         init;
    logic         readyin;
    logic [223:0] packet;
    logic         busy;
    logic [31:0]  seq;
    logic [31:0]  ack;
    logic [8:0]   flags;
    logic [15:0]  window;
    logic [31:0]  index;
    logic [63:0]  datain;
    logic         we;
    logic [31:0]  expected;
    logic         valid;
    logic         inorder;
    logic         readyout;
    logic [15:0]  badcount;

    modport master (
        output control, IRS, init, readyin, packet,
        input  busy, seq, ack, flags, window, index, datain, we,
               expected, valid, inorder, readyout, badcount
    );

    modport slave (
        input  control, IRS, init, readyin, packet,
        output busy, seq, ack, flags, window, index, datain, we,
               expected, valid, inorder, readyout, badcount
    );
endinterface

// File: rtl/parsepacket.sv
// Lasernet receive parser: latches a 224-bit packet, checks its ones-complement checksum,
// and writes in-order data words to the receive BRAM while tracking the next expected sequence.
module parsepacket (
    input  logic          clk,
    input  logic          reset,
    parsepacket_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

    state_t        state, state_nx;
    logic [223:0]  pkt;
    logic          valid_r, inorder_r;
    logic          we_q, readyout_q, valid_q, inorder_q;
    logic [31:0]   index_q, expected_q;
    logic [15:0]   badcount_q;

    logic [31:0]   sum;
    logic [16:0]   fold;
    logic [15:0]   csum;
    logic          good;
    logic          accept;

    wire [31:0] pkt_seq = pkt[191:160];

    // Octet 5 (words 4 and 5 counting from the LSB) carries the checksum and is left out of the sum.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 14; i++) begin
            if (i != 4 && i != 5)
                sum = sum + {16'd0, pkt[i*16 +: 16]};
        end
        fold = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
        csum = ~(fold[15:0] + {15'd0, fold[16]});
        good = (csum == pkt[95:80]) && (pkt[79:64] == 16'd0) && (pkt[127:121] == 7'd0);
    end

    assign accept = valid_r && inorder_r && !bus.control;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.readyin ? CHECK : IDLE;
            CHECK:   state_nx = WRITE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt        <= '0;
            valid_r    <= 1'b0;
            inorder_r  <= 1'b0;
            we_q       <= 1'b0;
            index_q    <= '0;
            readyout_q <= 1'b0;
            valid_q    <= 1'b0;
            inorder_q  <= 1'b0;
            expected_q <= bus.IRS + 32'd1;
            badcount_q <= '0;
        end else begin
            we_q       <= 1'b0;
            readyout_q <= 1'b0;
            case (state)
                IDLE: if (bus.readyin) pkt <= bus.packet;
                CHECK: begin
                    valid_r   <= good;
                    inorder_r <= (pkt_seq == expected_q);
                end
                WRITE: if (accept) begin
                    we_q    <= 1'b1;
                    index_q <= pkt_seq - bus.IRS - 32'd1;
                end
                DONE: begin
                    readyout_q <= 1'b1;
                    valid_q    <= valid_r;
                    inorder_q  <= inorder_r;
                    // we_q is high in DONE exactly when the packet was accepted in WRITE.
                    if (we_q) expected_q <= expected_q + 32'd1;
                    if (!valid_r && badcount_q != 16'hFFFF) badcount_q <= badcount_q + 16'd1;
                end
                default: ;
            endcase
            if (bus.init) expected_q <= bus.IRS + 32'd1;
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.seq      = pkt_seq;
    assign bus.ack      = pkt[159:128];
    assign bus.flags    = pkt[120:112];
    assign bus.window   = pkt[111:96];
    assign bus.datain   = pkt[63:0];
    assign bus.index    = index_q;
    assign bus.we       = we_q;
    assign bus.expected = expected_q;
    assign bus.valid    = valid_q;
    assign bus.inorder  = inorder_q;
    assign bus.readyout = readyout_q;
    assign bus.badcount = badcount_q;
endmodule

// File: tb/tb_parsepacket.sv
// Directed bench for parsepacket: each strobe pushes a predicted result to a scoreboard queue,
// which is popped and compared when the parser raises readyout.
module tb_parsepacket;
    logic clk = 1'b0;
    logic reset;
    parsepacket_if bus();

    parsepacket dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] idx;
        logic [63:0] data;
        logic        valid;
        logic        inorder;
        logic [31:0] exp_after;
        logic [15:0] bad_after;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [8:0]  flags;
        logic [15:0] window;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_irs;
    logic [31:0] m_expected;
    logic [15:0] m_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [223:0] mk(input logic [31:0] seq, input logic [31:0] ack,
                                        input logic [6:0] pad, input logic [8:0] fl,
                                        input logic [15:0] win, input logic [15:0] cs,
                                        input logic [15:0] lo, input logic [63:0] data);
        return {32'd0, seq, ack, pad, fl, win, cs, lo, data};
    endfunction

    // End-around-carry accumulation over all words except the checksum octet.
    function automatic logic [15:0] csum_of(input logic [223:0] p);
        logic [16:0] acc;
        acc = '0;
        for (int i = 0; i < 14; i++) begin
            if (i != 4 && i != 5) begin
                acc = acc + {1'b0, p[i*16 +: 16]};
                acc = {1'b0, acc[15:0]} + {16'd0, acc[16]};
            end
        end
        return ~acc[15:0];
    endfunction

    function automatic logic [223:0] with_cs(input logic [223:0] p);
        logic [223:0] q;
        q = p;
        q[95:80] = csum_of(p);
        return q;
    endfunction

    task automatic send(input logic [223:0] p, input bit ctl, input bit vexp,
                        input bit hold2, input bit init_done);
        exp_t e;
        int   wes, rdys;
        logic [31:0] o_seq, o_ack, o_exp;
        logic [8:0]  o_fl;
        logic [15:0] o_win, o_bad;
        logic        o_v, o_io;
        e.seq     = p[191:160];
        e.ack     = p[159:128];
        e.flags   = p[120:112];
        e.window  = p[111:96];
        e.data    = p[63:0];
        e.valid   = vexp;
        e.inorder = (e.seq == m_expected);
        e.wr      = vexp && e.inorder && !ctl;
        e.idx     = e.seq - m_irs - 32'd1;
        if (e.wr) m_expected = m_expected + 32'd1;
        if (init_done) m_expected = m_irs + 32'd1;
        if (!vexp && m_bad != 16'hFFFF) m_bad = m_bad + 16'd1;
        e.exp_after = m_expected;
        e.bad_after = m_bad;
        sb.push_back(e);

        bus.control = ctl;
        bus.packet  = p;
        bus.readyin = 1'b1;
        @(negedge clk);
        chk("busy_rise", bus.busy, 1);
        if (hold2) begin
            bus.packet = ~p;
            @(negedge clk);
        end
        bus.readyin = 1'b0;
        wes = 0; rdys = 0;
        o_seq = 'x; o_ack = 'x; o_exp = 'x; o_fl = 'x; o_win = 'x; o_bad = 'x; o_v = 'x; o_io = 'x;
        for (int i = 0; i < 12; i++) begin
            bus.init = 1'b0;
            if (bus.we) begin
                wes++;
                chk("index", bus.index, e.idx);
                chk("datain", bus.datain, e.data);
                if (init_done) bus.init = 1'b1;
            end
            if (bus.readyout) begin
                rdys++;
                if (rdys == 1) begin
                    o_v = bus.valid; o_io = bus.inorder; o_exp = bus.expected;
                    o_bad = bus.badcount; o_seq = bus.seq; o_ack = bus.ack;
                    o_fl = bus.flags; o_win = bus.window;
                    chk("busy_fall", bus.busy, 0);
                end
            end
            @(negedge clk);
        end
        bus.init = 1'b0;
        e = sb.pop_front();
        chk("we_count", wes, e.wr);
        chk("readyout_count", rdys, 1);
        chk("valid", o_v, e.valid);
        chk("inorder", o_io, e.inorder);
        chk("expected", o_exp, e.exp_after);
        chk("badcount", o_bad, e.bad_after);
        chk("seq", o_seq, e.seq);
        chk("ack", o_ack, e.ack);
        chk("flags", o_fl, e.flags);
        chk("window", o_win, e.window);
    endtask

    task automatic load_irs(input logic [31:0] irs);
        bus.IRS  = irs;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init   = 1'b0;
        m_irs      = irs;
        m_expected = irs + 32'd1;
        chk("init_expected", bus.expected, m_expected);
    endtask

    initial begin
        logic [223:0] pa, pb;
        int rdys;
        bus.control = 1'b0; bus.IRS = 32'h10; bus.init = 1'b0;
        bus.readyin = 1'b0; bus.packet = '0;
        reset = 1'b1;
        m_irs = 32'h10; m_expected = 32'h11; m_bad = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_expected", bus.expected, 32'h11);
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_readyout", bus.readyout, 0);
        chk("rst_badcount", bus.badcount, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_seq", bus.seq, 0);
        chk("rst_index", bus.index, 0);
        chk("rst_datain", bus.datain, 0);

        // Bad checksum first, then the good packet with its known checksum, then a replay.
        send(mk(32'h11, 32'h0, 7'd0, 9'h010, 16'h0040, 16'hFF9A, 16'h0, 64'h00000001_00000002), 0, 0, 0, 0);
        pa = mk(32'h11, 32'h0, 7'd0, 9'h010, 16'h0040, 16'hFF9B, 16'h0, 64'h00000001_00000002);
        send(pa, 0, 1, 0, 0);
        send(pa, 0, 1, 0, 0);
        // Good in-order packet under control phase, then the same in data phase.
        pb = with_cs(mk(32'h12, 32'hA5A5_0001, 7'd0, 9'h1FF, 16'hBEEF, 16'h0, 16'h0, 64'hDEADBEEF_CAFEF00D));
        send(pb, 1, 1, 0, 0);
        send(pb, 0, 1, 0, 0);
        // Format violations with otherwise correct checksums.
        send(with_cs(mk(32'h13, 32'h0, 7'h01, 9'h0, 16'h0, 16'h0, 16'h0, 64'h1)), 0, 0, 0, 0);
        send(with_cs(mk(32'h13, 32'h0, 7'd0, 9'h0, 16'h0, 16'h0, 16'h0001, 64'h1)), 0, 0, 0, 0);

        // Sequence wrap at 2^32.
        load_irs(32'hFFFF_FFFE);
        send(with_cs(mk(32'hFFFF_FFFF, 32'h7, 7'd0, 9'h002, 16'h1000, 16'h0, 16'h0, 64'h0123_4567_89AB_CDEF)), 0, 1, 0, 0);

        // init coinciding with an accepting DONE cycle overrides the increment.
        load_irs(32'h100);
        send(with_cs(mk(32'h101, 32'h0, 7'd0, 9'h010, 16'h0001, 16'h0, 16'h0, 64'h55)), 0, 1, 0, 1);

        // A second strobe while busy is dropped; only the first packet is reported.
        load_irs(32'h10);
        send(with_cs(mk(32'h11, 32'h9, 7'd0, 9'h010, 16'h0040, 16'h0, 16'h0, 64'h77)), 0, 1, 1, 0);

        // Reset asserted while in WRITE cancels the pending write.
        bus.packet  = with_cs(mk(32'h12, 32'h0, 7'd0, 9'h0, 16'h0, 16'h0, 16'h0, 64'h99));
        bus.readyin = 1'b1;
        @(negedge clk);
        bus.readyin = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_expected = m_irs + 32'd1;
        m_bad = 16'd0;
        chk("rstw_we", bus.we, 0);
        chk("rstw_busy", bus.busy, 0);
        chk("rstw_badcount", bus.badcount, m_bad);
        chk("rstw_expected", bus.expected, m_expected);
        rdys = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.readyout || bus.we) rdys++;
            @(negedge clk);
        end
        chk("rstw_no_output", rdys, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
